// File: rtl/snap_dbb_pkg.sv
// Shared types and constants for the DBB scratchpad responder.
package snap_dbb_pkg;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam int DBB_DATA_WIDTH = 512;
  localparam int BEAT_BYTES     = DBB_DATA_WIDTH / 8;
  localparam int BEAT_SHIFT     = 6;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_e;
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} rd_state_e;
endpackage

// File: rtl/snap_dbb_bram.sv
// Simple dual-port scratchpad: byte-enabled write port, registered read-first read port.
module snap_dbb_bram #(
  parameter int DATA_WIDTH = 512,
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                    clk,
  input  logic                    wr_en,
  input  logic [DEPTH_LOG2-1:0]   wr_addr,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic [DATA_WIDTH/8-1:0] wr_strb,
  input  logic                    rd_en,
  input  logic [DEPTH_LOG2-1:0]   rd_addr,
  output logic [DATA_WIDTH-1:0]   rd_data_p1
);
  logic [DATA_WIDTH-1:0] mem [2**DEPTH_LOG2];

  // stage p1: a same-cycle write to rd_addr is not visible until the next read
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < DATA_WIDTH/8; b++) begin
        if (wr_strb[b]) mem[wr_addr][b*8 +: 8] <= wr_data[b*8 +: 8];
      end
    end
    if (rd_en) rd_data_p1 <= mem[rd_addr];
  end
endmodule

// File: rtl/snap_dbb_mem_responder.sv
// AXI4 slave answering NVDLA core2dbb traffic from a local scratchpad; one write and one read burst in flight.
module snap_dbb_mem_responder
  import snap_dbb_pkg::*;
#(
  parameter int                    ID_WIDTH   = 1,
  parameter int                    ADDR_WIDTH = 64,
  parameter int                    DATA_WIDTH = 512,
  parameter int                    DEPTH_LOG2 = 10,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic                    ap_clk,
  input  logic                    ap_rst_n,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [ID_WIDTH-1:0]     s_axi_awid,
  input  logic [7:0]              s_axi_awlen,
  input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                    s_axi_wlast,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  output logic [ID_WIDTH-1:0]     s_axi_bid,
  output logic [1:0]              s_axi_bresp,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  input  logic [ID_WIDTH-1:0]     s_axi_arid,
  input  logic [7:0]              s_axi_arlen,
  input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready,
  output logic [ID_WIDTH-1:0]     s_axi_rid,
  output logic [DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]              s_axi_rresp,
  output logic                    s_axi_rlast
);
  localparam logic [ADDR_WIDTH-1:0] SPAN = ADDR_WIDTH'(BEAT_BYTES) << DEPTH_LOG2;

  function automatic logic addr_dec_err(input logic [ADDR_WIDTH-1:0] a);
    return (a < BASE_ADDR) || ((a - BASE_ADDR) >= SPAN);
  endfunction

  function automatic logic [DEPTH_LOG2-1:0] beat_index(input logic [ADDR_WIDTH-1:0] a);
    return DEPTH_LOG2'((a - BASE_ADDR) >> BEAT_SHIFT);
  endfunction

  wr_state_e               wr_state, wr_state_nx;
  rd_state_e               rd_state, rd_state_nx;
  logic                    live;
  logic [ID_WIDTH-1:0]     wr_id, rd_id;
  logic [1:0]              wr_resp;
  logic                    wr_dec, wr_bad, rd_dec;
  logic [7:0]              wr_len, wr_cnt, rd_len, rd_cnt;
  logic [DEPTH_LOG2-1:0]   wr_idx, rd_idx;
  logic [DATA_WIDTH-1:0]   rd_data_p1;
  logic                    aw_hs, w_hs, ar_hs, r_hs, w_last_beat;

  // ready is held low until the first clock after reset releases
  assign s_axi_awready = live && (wr_state == W_IDLE);
  assign s_axi_wready  = (wr_state == W_DATA);
  assign s_axi_bvalid  = (wr_state == W_RESP);
  assign s_axi_bid     = wr_id;
  assign s_axi_bresp   = wr_resp;
  assign s_axi_arready = live && (rd_state == R_IDLE);
  assign s_axi_rvalid  = (rd_state == R_DATA);
  assign s_axi_rlast   = s_axi_rvalid && (rd_cnt == rd_len);
  assign s_axi_rid     = rd_id;
  assign s_axi_rresp   = rd_dec ? RESP_DECERR : RESP_OKAY;
  assign s_axi_rdata   = rd_dec ? '0 : rd_data_p1;

  assign aw_hs       = s_axi_awvalid && s_axi_awready;
  assign w_hs        = s_axi_wvalid && s_axi_wready;
  assign ar_hs       = s_axi_arvalid && s_axi_arready;
  assign r_hs        = s_axi_rvalid && s_axi_rready;
  assign w_last_beat = (wr_cnt == wr_len);

  always_comb begin
    wr_state_nx = wr_state;
    case (wr_state)
      W_IDLE:  if (aw_hs) wr_state_nx = W_DATA;
      W_DATA:  if (w_hs && w_last_beat) wr_state_nx = W_RESP;
      W_RESP:  if (s_axi_bready) wr_state_nx = W_IDLE;
      default: wr_state_nx = W_IDLE;
    endcase
  end

  always_comb begin
    rd_state_nx = rd_state;
    case (rd_state)
      R_IDLE:  if (ar_hs) rd_state_nx = R_FETCH;
      R_FETCH: rd_state_nx = R_DATA;
      R_DATA:  if (r_hs) rd_state_nx = s_axi_rlast ? R_IDLE : R_FETCH;
      default: rd_state_nx = R_IDLE;
    endcase
  end

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      wr_state <= W_IDLE;
      rd_state <= R_IDLE;
      live     <= 1'b0;
      wr_id    <= '0;
      rd_id    <= '0;
      wr_resp  <= RESP_OKAY;
      rd_dec   <= 1'b0;
    end else begin
      wr_state <= wr_state_nx;
      rd_state <= rd_state_nx;
      live     <= 1'b1;
      if (aw_hs) wr_id <= s_axi_awid;
      if (ar_hs) begin
        rd_id  <= s_axi_arid;
        rd_dec <= addr_dec_err(s_axi_araddr);
      end
      // a misplaced or missing wlast anywhere in the burst downgrades to SLVERR
      if (w_hs && w_last_beat)
        wr_resp <= wr_dec ? RESP_DECERR :
                   (wr_bad || (s_axi_wlast != w_last_beat)) ? RESP_SLVERR : RESP_OKAY;
    end
  end

  always_ff @(posedge ap_clk) begin
    if (aw_hs) begin
      wr_len <= s_axi_awlen;
      wr_cnt <= 8'd0;
      wr_idx <= beat_index(s_axi_awaddr);
      wr_dec <= addr_dec_err(s_axi_awaddr);
      wr_bad <= 1'b0;
    end else if (w_hs) begin
      wr_cnt <= wr_cnt + 8'd1;
      wr_idx <= wr_idx + DEPTH_LOG2'(1);
      wr_bad <= wr_bad || (s_axi_wlast != w_last_beat);
    end
    if (ar_hs) begin
      rd_len <= s_axi_arlen;
      rd_cnt <= 8'd0;
      rd_idx <= beat_index(s_axi_araddr);
    end else if (r_hs && !s_axi_rlast) begin
      rd_cnt <= rd_cnt + 8'd1;
      rd_idx <= rd_idx + DEPTH_LOG2'(1);
    end
  end

  snap_dbb_bram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_bram (
    .clk        (ap_clk),
    .wr_en      (w_hs && !wr_dec),
    .wr_addr    (wr_idx),
    .wr_data    (s_axi_wdata),
    .wr_strb    (s_axi_wstrb),
    .rd_en      (rd_state == R_FETCH),
    .rd_addr    (rd_idx),
    .rd_data_p1 (rd_data_p1)
  );
endmodule

// File: tb/tb_snap_dbb_mem_responder.sv
// Randomized bench for snap_dbb_mem_responder against a byte-level scratchpad model.
module tb_snap_dbb_mem_responder;
  localparam int ID_W = 2;
  localparam int DW = 512;
  localparam int SW = DW / 8;
  localparam int DL = 10;
  localparam int NBEAT = 1 << DL;
  localparam logic [63:0] BASE = 64'h0000_0000_0001_0000;

  logic clk = 1'b0, rst_n = 1'b0;
  logic awvalid = 0, awready, wvalid = 0, wready, wlast = 0, bvalid, bready = 0;
  logic arvalid = 0, arready, rvalid, rready = 0, rlast;
  logic [ID_W-1:0] awid = '0, arid = '0, bid, rid;
  logic [7:0] awlen = '0, arlen = '0;
  logic [63:0] awaddr = '0, araddr = '0;
  logic [DW-1:0] wdata = '0, rdata;
  logic [SW-1:0] wstrb = '0;
  logic [1:0] bresp, rresp;

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc++;

  snap_dbb_mem_responder #(
    .ID_WIDTH(ID_W), .ADDR_WIDTH(64), .DATA_WIDTH(DW), .DEPTH_LOG2(DL), .BASE_ADDR(BASE)
  ) dut (
    .ap_clk(clk), .ap_rst_n(rst_n),
    .s_axi_awvalid(awvalid), .s_axi_awready(awready), .s_axi_awid(awid), .s_axi_awlen(awlen),
    .s_axi_awaddr(awaddr), .s_axi_wvalid(wvalid), .s_axi_wready(wready), .s_axi_wdata(wdata),
    .s_axi_wstrb(wstrb), .s_axi_wlast(wlast), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_bid(bid), .s_axi_bresp(bresp), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_arid(arid), .s_axi_arlen(arlen), .s_axi_araddr(araddr), .s_axi_rvalid(rvalid),
    .s_axi_rready(rready), .s_axi_rid(rid), .s_axi_rdata(rdata), .s_axi_rresp(rresp),
    .s_axi_rlast(rlast)
  );

  int n_tests = 0, n_fail = 0;
  logic [DW-1:0] model [NBEAT];
  logic [DW-1:0] wd [256];
  logic [SW-1:0] ws [256];
  logic [DW-1:0] rd_q [256];
  logic [1:0] rr_q [256];
  logic rl_q [256];
  logic [ID_W-1:0] rid_q [256];

  function automatic logic [DW-1:0] rand512();
    logic [DW-1:0] v;
    for (int i = 0; i < DW/32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic bit is_dec(input logic [63:0] a);
    return (a < BASE) || (a >= BASE + 64'(NBEAT * 64));
  endfunction

  function automatic int beat_of(input logic [63:0] a, input int i);
    return int'((((a - BASE) / 64) + 64'(i)) % 64'(NBEAT));
  endfunction

  task automatic model_write(input logic [63:0] a, input int nbeats);
    if (is_dec(a)) return;
    for (int i = 0; i < nbeats; i++)
      for (int b = 0; b < SW; b++)
        if (ws[i][b]) model[beat_of(a, i)][b*8 +: 8] = wd[i][b*8 +: 8];
  endtask

  task automatic do_write(input logic [63:0] a, input logic [ID_W-1:0] id, input int len,
                          input int wlast_at, output logic [1:0] resp, output logic [ID_W-1:0] bid_o,
                          output int lat);
    int t0, budget;
    resp = 2'bxx; bid_o = 'x; lat = -1;
    awvalid = 1; awaddr = a; awid = id; awlen = 8'(len);
    budget = 0;
    while (!awready) begin
      @(posedge clk); #1;
      if (++budget > 50) begin
        n_tests++; n_fail++; $display("FAIL aw_timeout awready=%b required=1", awready);
        awvalid = 0; return;
      end
    end
    t0 = cyc;
    @(posedge clk); #1;
    awvalid = 0;
    for (int i = 0; i <= len; i++) begin
      wvalid = 1; wdata = wd[i]; wstrb = ws[i]; wlast = (i == wlast_at);
      budget = 0;
      while (!wready) begin
        @(posedge clk); #1;
        if (++budget > 50) begin
          n_tests++; n_fail++; $display("FAIL w_timeout beat=%0d wready=%b required=1", i, wready);
          wvalid = 0; wlast = 0; return;
        end
      end
      @(posedge clk); #1;
    end
    wvalid = 0; wlast = 0;
    budget = 0;
    while (!bvalid) begin
      @(posedge clk); #1;
      if (++budget > 50) begin
        n_tests++; n_fail++; $display("FAIL b_timeout bvalid=%b required=1", bvalid);
        return;
      end
    end
    lat = cyc - t0; resp = bresp; bid_o = bid;
    bready = 1;
    @(posedge clk); #1;
    bready = 0;
  endtask

  task automatic do_read(input logic [63:0] a, input logic [ID_W-1:0] id, input int len,
                         input int stall_at, input int stall_n);
    int t0, prev, budget;
    logic [DW-1:0] s_d; logic [1:0] s_r; logic s_l; logic [ID_W-1:0] s_i;
    for (int i = 0; i < 256; i++) begin rd_q[i] = 'x; rr_q[i] = 'x; rl_q[i] = 1'bx; rid_q[i] = 'x; end
    arvalid = 1; araddr = a; arid = id; arlen = 8'(len);
    budget = 0;
    while (!arready) begin
      @(posedge clk); #1;
      if (++budget > 50) begin
        n_tests++; n_fail++; $display("FAIL ar_timeout arready=%b required=1", arready);
        arvalid = 0; return;
      end
    end
    t0 = cyc; prev = t0;
    @(posedge clk); #1;
    arvalid = 0; rready = 1;
    for (int i = 0; i <= len; i++) begin
      budget = 0;
      while (!rvalid) begin
        @(posedge clk); #1;
        if (++budget > 50) begin
          n_tests++; n_fail++; $display("FAIL r_timeout beat=%0d rvalid=%b required=1", i, rvalid);
          rready = 0; return;
        end
      end
      n_tests++;
      if ((cyc - prev) !== 2) begin
        n_fail++; $display("FAIL r_latency beat=%0d got=%0d required=2", i, cyc - prev);
      end
      if (i == stall_at) begin
        rready = 0;
        s_d = rdata; s_r = rresp; s_l = rlast; s_i = rid;
        for (int k = 0; k < stall_n; k++) begin
          @(posedge clk); #1;
          n_tests++;
          if ({rvalid, rdata, rresp, rlast, rid} !== {1'b1, s_d, s_r, s_l, s_i}) begin
            n_fail++;
            $display("FAIL r_stall_stable cyc=%0d rvalid=%b rlast=%b rresp=%0d rid=%0d required 1/%b/%0d/%0d",
                     k, rvalid, rlast, rresp, rid, s_l, s_r, s_i);
          end
        end
        rready = 1;
      end
      rd_q[i] = rdata; rr_q[i] = rresp; rl_q[i] = rlast; rid_q[i] = rid;
      prev = cyc;
      @(posedge clk); #1;
    end
    rready = 0;
  endtask

  task automatic test_reset();
    rst_n = 0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if ({awready, wready, bvalid, arready, rvalid, rlast} !== 6'b0) begin
      n_fail++; $display("FAIL reset_valids got=%b required=000000", {awready, wready, bvalid, arready, rvalid, rlast});
    end
    n_tests++;
    if ({bresp, rresp, bid, rid} !== '0) begin
      n_fail++; $display("FAIL reset_fields bresp=%0d rresp=%0d bid=%0d rid=%0d required all 0", bresp, rresp, bid, rid);
    end
    rst_n = 1;
    @(posedge clk); #1;
    n_tests++;
    if ({awready, arready} !== 2'b11) begin
      n_fail++; $display("FAIL reset_release awready/arready=%b required=11", {awready, arready});
    end
  endtask

  task automatic test_fill();
    logic [1:0] r; logic [ID_W-1:0] b; int lat;
    for (int i = 0; i < 256; i++) begin wd[i] = '0; ws[i] = '1; end
    for (int k = 0; k < NBEAT/256; k++) begin
      do_write(BASE + 64'(k * 256 * 64), 2'd0, 255, 255, r, b, lat);
      n_tests++;
      if (r !== 2'b00 || lat !== 257) begin
        n_fail++; $display("FAIL fill_write chunk=%0d bresp=%0d lat=%0d required 0/257", k, r, lat);
      end
    end
  endtask

  task automatic test_basic();
    logic [1:0] r; logic [ID_W-1:0] b; int lat;
    for (int i = 0; i < 4; i++) begin wd[i] = DW'(8'hA0 + i); ws[i] = '1; end
    do_write(BASE + 64'h40, 2'd1, 3, 3, r, b, lat);
    model_write(BASE + 64'h40, 4);
    n_tests++;
    if ({r, b} !== {2'b00, 2'd1} || lat !== 5) begin
      n_fail++; $display("FAIL basic_write bresp=%0d bid=%0d lat=%0d required 0/1/5", r, b, lat);
    end
    do_read(BASE + 64'h40, 2'd1, 3, -1, 0);
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if ({rd_q[i], rr_q[i], rl_q[i], rid_q[i]} !== {DW'(8'hA0 + i), 2'b00, (i == 3), 2'd1}) begin
        n_fail++;
        $display("FAIL basic_read beat=%0d data=%0h resp=%0d last=%b id=%0d required %0h/0/%b/1",
                 i, rd_q[i][31:0], rr_q[i], rl_q[i], rid_q[i], 8'hA0 + i, i == 3);
      end
    end
  endtask

  task automatic test_strobe();
    logic [1:0] r; logic [ID_W-1:0] b; int lat;
    wd[0] = {SW{8'hFF}}; ws[0] = SW'(1);
    do_write(BASE + 64'h200, 2'd2, 0, 0, r, b, lat);
    model_write(BASE + 64'h200, 1);
    n_tests++;
    if (r !== 2'b00 || lat !== 2) begin
      n_fail++; $display("FAIL strobe_write bresp=%0d lat=%0d required 0/2", r, lat);
    end
    do_read(BASE + 64'h200, 2'd2, 0, -1, 0);
    n_tests++;
    if (rd_q[0] !== DW'(8'hFF) || rd_q[0] !== model[8]) begin
      n_fail++; $display("FAIL strobe_read data_lo=%0h required=ff upper bytes 0", rd_q[0][63:0]);
    end
  endtask

  task automatic test_wrap();
    logic [1:0] r; logic [ID_W-1:0] b; int lat;
    for (int i = 0; i < 2; i++) begin wd[i] = rand512(); ws[i] = '1; end
    do_write(BASE + 64'hFFC0, 2'd3, 1, 1, r, b, lat);
    model_write(BASE + 64'hFFC0, 2);
    n_tests++;
    if ({r, b} !== {2'b00, 2'd3}) begin
      n_fail++; $display("FAIL wrap_write bresp=%0d bid=%0d required 0/3", r, b);
    end
    do_read(BASE, 2'd0, 0, -1, 0);
    n_tests++;
    if (rd_q[0] !== wd[1] || rr_q[0] !== 2'b00) begin
      n_fail++; $display("FAIL wrap_beat0 data=%0h required=%0h", rd_q[0][31:0], wd[1][31:0]);
    end
    do_read(BASE + 64'hFFC0, 2'd1, 1, -1, 0);
    n_tests++;
    if (rd_q[0] !== model[NBEAT-1] || rd_q[1] !== model[0] || rl_q[1] !== 1'b1) begin
      n_fail++; $display("FAIL wrap_read d0=%0h d1=%0h last=%b required %0h/%0h/1",
                         rd_q[0][31:0], rd_q[1][31:0], rl_q[1], model[NBEAT-1][31:0], model[0][31:0]);
    end
  endtask

  task automatic test_decerr();
    logic [1:0] r; logic [ID_W-1:0] b; int lat;
    do_read(BASE + 64'h10000, 2'd1, 2, -1, 0);
    for (int i = 0; i < 3; i++) begin
      n_tests++;
      if ({rd_q[i], rr_q[i], rl_q[i]} !== {DW'(0), 2'b11, (i == 2)}) begin
        n_fail++; $display("FAIL decerr_read_hi beat=%0d data=%0h resp=%0d last=%b required 0/3/%b",
                           i, rd_q[i][31:0], rr_q[i], rl_q[i], i == 2);
      end
    end
    do_read(BASE - 64'h40, 2'd2, 0, -1, 0);
    n_tests++;
    if ({rd_q[0], rr_q[0]} !== {DW'(0), 2'b11}) begin
      n_fail++; $display("FAIL decerr_read_lo data=%0h resp=%0d required 0/3", rd_q[0][31:0], rr_q[0]);
    end
    for (int i = 0; i < 2; i++) begin wd[i] = rand512(); ws[i] = '1; end
    do_write(BASE + 64'h10000, 2'd1, 1, 1, r, b, lat);
    model_write(BASE + 64'h10000, 2);
    n_tests++;
    if (r !== 2'b11) begin
      n_fail++; $display("FAIL decerr_write bresp=%0d required=3", r);
    end
    do_read(BASE, 2'd0, 1, -1, 0);
    n_tests++;
    if (rd_q[0] !== model[0] || rd_q[1] !== model[1]) begin
      n_fail++; $display("FAIL decerr_untouched d0=%0h d1=%0h required %0h/%0h",
                         rd_q[0][31:0], rd_q[1][31:0], model[0][31:0], model[1][31:0]);
    end
  endtask

  task automatic test_wlast();
    logic [1:0] r; logic [ID_W-1:0] b; int lat;
    for (int i = 0; i < 4; i++) begin wd[i] = rand512(); ws[i] = SW'({$urandom, $urandom}); end
    do_write(BASE + 64'h800, 2'd2, 3, 1, r, b, lat);
    model_write(BASE + 64'h800, 4);
    n_tests++;
    if (r !== 2'b10 || lat !== 5) begin
      n_fail++; $display("FAIL wlast_early bresp=%0d lat=%0d required 2/5", r, lat);
    end
    do_write(BASE + 64'hA00, 2'd0, 1, -1, r, b, lat);
    model_write(BASE + 64'hA00, 2);
    n_tests++;
    if (r !== 2'b10 || lat !== 3) begin
      n_fail++; $display("FAIL wlast_missing bresp=%0d lat=%0d required 2/3", r, lat);
    end
    do_read(BASE + 64'h800, 2'd3, 3, -1, 0);
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (rd_q[i] !== model[beat_of(BASE + 64'h800, i)]) begin
        n_fail++; $display("FAIL wlast_data beat=%0d data=%0h required=%0h",
                           i, rd_q[i][31:0], model[beat_of(BASE + 64'h800, i)][31:0]);
      end
    end
  endtask

  task automatic test_stall_reset();
    logic [1:0] r; logic [ID_W-1:0] b; int lat;
    do_read(BASE + 64'h40, 2'd3, 5, 2, 5);
    for (int i = 0; i < 6; i++) begin
      n_tests++;
      if ({rd_q[i], rl_q[i], rid_q[i]} !== {model[beat_of(BASE + 64'h40, i)], (i == 5), 2'd3}) begin
        n_fail++; $display("FAIL stall_data beat=%0d data=%0h last=%b required=%0h/%b",
                           i, rd_q[i][31:0], rl_q[i], model[beat_of(BASE + 64'h40, i)][31:0], i == 5);
      end
    end
    for (int i = 0; i < 8; i++) begin wd[i] = rand512(); ws[i] = '1; end
    awvalid = 1; awaddr = BASE + 64'h1000; awid = 2'd2; awlen = 8'd7;
    for (int k = 0; k < 50 && !awready; k++) begin @(posedge clk); #1; end
    @(posedge clk); #1;
    awvalid = 0;
    for (int i = 0; i < 3; i++) begin
      wvalid = 1; wdata = wd[i]; wstrb = ws[i]; wlast = 0;
      n_tests++;
      if (wready !== 1'b1) begin
        n_fail++; $display("FAIL abort_wready beat=%0d wready=%b required=1", i, wready);
      end
      @(posedge clk); #1;
    end
    wvalid = 0;
    model_write(BASE + 64'h1000, 3);
    rst_n = 0;
    @(posedge clk); #1;
    n_tests++;
    if ({awready, wready, bvalid, arready, rvalid} !== 5'b0) begin
      n_fail++; $display("FAIL abort_reset valids=%b required=00000", {awready, wready, bvalid, arready, rvalid});
    end
    @(posedge clk); #1;
    rst_n = 1;
    @(posedge clk); #1;
    n_tests++;
    if ({bvalid, awready, arready} !== 3'b011) begin
      n_fail++; $display("FAIL abort_release bvalid/awready/arready=%b required=011", {bvalid, awready, arready});
    end
    for (int i = 0; i < 2; i++) begin wd[i] = rand512(); ws[i] = '1; end
    do_write(BASE + 64'h2000, 2'd1, 1, 1, r, b, lat);
    model_write(BASE + 64'h2000, 2);
    n_tests++;
    if ({r, b} !== {2'b00, 2'd1} || lat !== 3) begin
      n_fail++; $display("FAIL post_reset_write bresp=%0d bid=%0d lat=%0d required 0/1/3", r, b, lat);
    end
    do_read(BASE + 64'h1000, 2'd0, 7, -1, 0);
    for (int i = 0; i < 8; i++) begin
      n_tests++;
      if (rd_q[i] !== model[beat_of(BASE + 64'h1000, i)]) begin
        n_fail++; $display("FAIL preserved_data beat=%0d data=%0h required=%0h",
                           i, rd_q[i][31:0], model[beat_of(BASE + 64'h1000, i)][31:0]);
      end
    end
  endtask

  task automatic test_random();
    logic [1:0] r, exp_r; logic [ID_W-1:0] b, id; int lat, len, wl;
    logic [63:0] a;
    bit dec;
    for (int n = 0; n < 30; n++) begin
      case ($urandom_range(0, 9))
        0: a = BASE + 64'h10000 + 64'($urandom_range(0, 32'hFFFF));
        1: a = BASE - 64'($urandom_range(1, 32'hFFFF));
        default: a = BASE + 64'($urandom_range(0, NBEAT - 1) * 64 + $urandom_range(0, 63));
      endcase
      len = $urandom_range(0, 15);
      id = ID_W'($urandom);
      dec = is_dec(a);
      if ($urandom_range(0, 1) == 0) begin
        for (int i = 0; i <= len; i++) begin wd[i] = rand512(); ws[i] = SW'({$urandom, $urandom}); end
        wl = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 16) : len;
        exp_r = dec ? 2'b11 : (wl != len) ? 2'b10 : 2'b00;
        do_write(a, id, len, wl, r, b, lat);
        model_write(a, len + 1);
        n_tests++;
        if ({r, b} !== {exp_r, id} || lat !== len + 2) begin
          n_fail++; $display("FAIL rand_write n=%0d bresp=%0d bid=%0d lat=%0d required %0d/%0d/%0d",
                             n, r, b, lat, exp_r, id, len + 2);
        end
      end else begin
        do_read(a, id, len, $urandom_range(0, 20), $urandom_range(1, 3));
        for (int i = 0; i <= len; i++) begin
          n_tests++;
          if ({rd_q[i], rr_q[i], rl_q[i], rid_q[i]} !==
              {(dec ? DW'(0) : model[beat_of(a, i)]), (dec ? 2'b11 : 2'b00), (i == len), id}) begin
            n_fail++; $display("FAIL rand_read n=%0d beat=%0d data=%0h resp=%0d last=%b id=%0d required %0h/%0d/%b/%0d",
                               n, i, rd_q[i][31:0], rr_q[i], rl_q[i], rid_q[i],
                               dec ? 32'h0 : model[beat_of(a, i)][31:0], dec ? 3 : 0, i == len, id);
          end
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < NBEAT; i++) model[i] = '0;
    test_reset();
    test_fill();
    test_basic();
    test_strobe();
    test_wrap();
    test_decerr();
    test_wlast();
    test_stall_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
